// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
// pulse_sequencer : walks a shared pulse generator through a table of
//                   {period, pulse count} steps with a busy/done handshake.
// Revision 1.0 - initial release
// ============================================================================
module pulse_sequencer #(
    parameter int unsigned N       = 8,
    parameter int unsigned STEPS   = 4,
    parameter int unsigned C       = 4,
    parameter bit          LOOP_EN = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_we_i,
    input  logic [$clog2(STEPS)-1:0] cfg_addr_i,
    input  logic [N-1:0]             cfg_ticks_i,
    input  logic [C-1:0]             cfg_count_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     loop_i,
    input  logic                     gen_pulse_i,
    output logic                     gen_rst_o,
    output logic                     gen_ena_o,
    output logic [N-1:0]             gen_ticks_o,
    output logic                     out_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(STEPS)-1:0] step_o
);
    localparam int unsigned   AW        = $clog2(STEPS);
    localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic [C-1:0]  cnt_q, cnt_d;
    logic [C-1:0]  cnt_inc;
    logic [N-1:0]  ticks_q [STEPS];
    logic [C-1:0]  count_q [STEPS];
    logic [N-1:0]  gen_ticks_q;
    logic          gen_rst_q, gen_ena_q, busy_q, done_q;
    logic          cfg_open;

    assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                ticks_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else if (cfg_we_i && cfg_open) begin
            ticks_q[cfg_addr_i] <= cfg_ticks_i;
            count_q[cfg_addr_i] <= cfg_count_i;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + C'(1);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                if (count_q[step_q] != '0) begin
                    state_d = S_RUN;
                end else if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + AW'(1);
                end
            end
            S_RUN: begin
                if (gen_pulse_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == count_q[step_q]) begin
                        if (step_q == LAST_STEP) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                            step_d  = step_q + AW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (LOOP_EN && loop_i) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition above, including a step advance.
        if (abort_i) begin
            state_d = S_IDLE;
            step_d  = step_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            gen_ticks_q <= '0;
            gen_rst_q   <= 1'b1;
            gen_ena_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            gen_rst_q <= (state_d != S_RUN);
            gen_ena_q <= (state_d == S_RUN);
            busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            if (state_q == S_LOAD) begin
                gen_ticks_q <= ticks_q[step_q];
            end
        end
    end

    assign gen_rst_o   = gen_rst_q;
    assign gen_ena_o   = gen_ena_q;
    assign gen_ticks_o = gen_ticks_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign step_o      = step_q;
    assign out_o       = gen_pulse_i && (state_q == S_RUN) && !abort_i;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pulse_sequencer : drives two sequencers (LOOP_EN=0 and LOOP_EN=1), each
//                      paired with a behavioural pulse generator.
// Revision 1.0 - initial release
// ============================================================================
module tb_pulse_sequencer;
    localparam int STEPS = 4;

    typedef struct packed {
        logic       out;
        logic       busy;
        logic       done;
        logic       grst;
        logic       ena;
        logic [1:0] step;
        logic [7:0] ticks;
    } smp_t;

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, start, abort, loop;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_ticks;
    logic [3:0] cfg_count;

    wire        gen_rst0, gen_ena0, out0, busy0, done0, gen_pulse0;
    wire  [7:0] gen_ticks0;
    wire  [1:0] step0;
    logic [7:0] gcnt0;
    wire        gen_rst1, gen_ena1, out1, busy1, done1, gen_pulse1;
    wire  [7:0] gen_ticks1;
    wire  [1:0] step1;
    logic [7:0] gcnt1;

    logic [7:0] tbl_t [STEPS];
    logic [3:0] tbl_c [STEPS];
    smp_t       expq[$], exp0[$], exp1[$], obs0[$], obs1[$];
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    pulse_sequencer #(.N(8), .STEPS(STEPS), .C(4), .LOOP_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_ticks_i(cfg_ticks), .cfg_count_i(cfg_count), .start_i(start),
        .abort_i(abort), .loop_i(loop), .gen_pulse_i(gen_pulse0),
        .gen_rst_o(gen_rst0), .gen_ena_o(gen_ena0), .gen_ticks_o(gen_ticks0),
        .out_o(out0), .busy_o(busy0), .done_o(done0), .step_o(step0)
    );

    pulse_sequencer #(.N(8), .STEPS(STEPS), .C(4), .LOOP_EN(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_ticks_i(cfg_ticks), .cfg_count_i(cfg_count), .start_i(start),
        .abort_i(abort), .loop_i(loop), .gen_pulse_i(gen_pulse1),
        .gen_rst_o(gen_rst1), .gen_ena_o(gen_ena1), .gen_ticks_o(gen_ticks1),
        .out_o(out1), .busy_o(busy1), .done_o(done1), .step_o(step1)
    );

    // Generator: one pulse every gen_ticks+1 cycles while enabled and out of reset.
    always @(posedge clk) begin
        if (gen_rst0 || !gen_ena0)     gcnt0 <= '0;
        else if (gcnt0 == gen_ticks0)  gcnt0 <= '0;
        else                           gcnt0 <= gcnt0 + 8'd1;
        if (gen_rst1 || !gen_ena1)     gcnt1 <= '0;
        else if (gcnt1 == gen_ticks1)  gcnt1 <= '0;
        else                           gcnt1 <= gcnt1 + 8'd1;
    end
    assign gen_pulse0 = !gen_rst0 && gen_ena0 && (gcnt0 == gen_ticks0);
    assign gen_pulse1 = !gen_rst1 && gen_ena1 && (gcnt1 == gen_ticks1);

    // Expected trace of one pass: a LOAD per entry, count*(ticks+1) RUN cycles
    // for non-skipped entries with a pulse on every (ticks+1)-th, then DONE.
    function automatic void push_pass();
        smp_t e;
        for (int s = 0; s < STEPS; s++) begin
            e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'(s), 8'h00};
            expq.push_back(e);
            for (int k = 0; k < int'(tbl_c[s]) * (int'(tbl_t[s]) + 1); k++) begin
                e = {(k % (int'(tbl_t[s]) + 1)) == int'(tbl_t[s]), 1'b1, 1'b0, 1'b0, 1'b1,
                     2'(s), tbl_t[s]};
                expq.push_back(e);
            end
        end
        e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'(STEPS - 1), 8'h00};
        expq.push_back(e);
    endfunction

    function automatic void push_idle(input int n);
        smp_t e;
        e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'(STEPS - 1), 8'h00};
        for (int i = 0; i < n; i++) expq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int t, input int c);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(a);
        cfg_ticks = 8'(t);
        cfg_count = 4'(c);
        tick();
        cfg_we    = 1'b0;
        tbl_t[a]  = 8'(t);
        tbl_c[a]  = 4'(c);
    endtask

    // Pulses start, records n samples; after sample poke_at it strobes
    // cfg_we+start (preset cfg data), after sample drop_at it clears loop.
    task automatic capture(input int n, input int poke_at, input int drop_at);
        smp_t s;
        obs0  = {};
        obs1  = {};
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            start  = 1'b0;
            cfg_we = 1'b0;
            if (i == drop_at) loop = 1'b0;
            s = {out0, busy0, done0, gen_rst0, gen_ena0, step0, gen_ticks0};
            obs0.push_back(s);
            s = {out1, busy1, done1, gen_rst1, gen_ena1, step1, gen_ticks1};
            obs1.push_back(s);
            if (i == poke_at) begin
                cfg_we = 1'b1;
                start  = 1'b1;
            end
        end
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({gen_rst0, gen_ena0, gen_ticks0, out0, busy0, done0, step0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            mismatched++;
            $display("FAIL reset_state got rst=%b ena=%b ticks=%h out=%b busy=%b done=%b step=%0d",
                     gen_rst0, gen_ena0, gen_ticks0, out0, busy0, done0, step0);
        end
        rst_n = 1'b1;
        tick();
        wr(0, 3, 2);
        wr(2, 2, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!gen_ena0 && w < 20) begin tick(); w++; end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        compared++;
        if ({gen_rst0, busy0, done0, out0, step0, gen_ena0} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0} || w >= 20) begin
            mismatched++;
            $display("FAIL reset_mid_run got rst=%b busy=%b done=%b out=%b step=%0d ena=%b wait=%0d",
                     gen_rst0, busy0, done0, out0, step0, gen_ena0, w);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < STEPS; i++) begin tbl_t[i] = '0; tbl_c[i] = '0; end
        tick();
        expq = {};
        push_pass();
        push_idle(2);
        capture(expq.size(), -1, -1);
        for (int i = 0; i < expq.size(); i++) begin
            smp_t o;
            o = obs0[i];
            if (expq[i].grst) o.ticks = '0;
            compared++;
            if (o !== expq[i]) begin
                mismatched++;
                $display("FAIL reset_cleared_table cycle %0d got %h expected %h", i, o, expq[i]);
            end
        end
    endtask

    task automatic test_single_step();
        int pulses, dones;
        wr(0, 3, 2);
        for (int a = 1; a < STEPS; a++) wr(a, int'($urandom_range(0, 15)), 0);
        expq = {};
        push_pass();
        push_idle(2);
        capture(expq.size(), -1, -1);
        pulses = 0;
        dones  = 0;
        for (int i = 0; i < expq.size(); i++) begin
            smp_t o;
            o = obs0[i];
            pulses += int'(o.out);
            dones  += int'(o.done);
            if (expq[i].grst) o.ticks = '0;
            compared++;
            if (o !== expq[i]) begin
                mismatched++;
                $display("FAIL single_step cycle %0d got %h expected %h", i, o, expq[i]);
            end
        end
        compared++;
        if (pulses != 2 || dones != 1) begin
            mismatched++;
            $display("FAIL single_step_counts got pulses=%0d dones=%0d expected 2/1", pulses, dones);
        end
    endtask

    task automatic test_multi_step();
        int pulses;
        wr(0, 3, 2);
        wr(1, 1, 3);
        wr(2, 0, 0);
        wr(3, 7, 1);
        expq = {};
        push_pass();
        push_idle(2);
        capture(expq.size(), -1, -1);
        pulses = 0;
        for (int i = 0; i < expq.size(); i++) begin
            smp_t o;
            o = obs0[i];
            pulses += int'(o.out);
            if (expq[i].grst) o.ticks = '0;
            compared++;
            if (o !== expq[i]) begin
                mismatched++;
                $display("FAIL multi_step cycle %0d got %h expected %h", i, o, expq[i]);
            end
        end
        compared++;
        if (pulses != 6) begin
            mismatched++;
            $display("FAIL multi_step_pulses got %0d expected 6", pulses);
        end
    endtask

    task automatic test_abort();
        int np, w, seen_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        np = 0;
        w  = 0;
        // Abort on the pulse that would otherwise finish step 1.
        while (np < 3 && w < 200) begin
            if (step0 == 2'd1 && gen_pulse0) np++;
            if (np < 3) begin tick(); w++; end
        end
        abort = 1'b1;
        #1;
        compared++;
        if (out0 !== 1'b0 || w >= 200) begin
            mismatched++;
            $display("FAIL abort_out got out=%b wait=%0d expected out=0", out0, w);
        end
        tick();
        abort = 1'b0;
        compared++;
        if ({busy0, done0, gen_rst0, gen_ena0} !== 4'b0010) begin
            mismatched++;
            $display("FAIL abort_idle got busy=%b done=%b rst=%b ena=%b", busy0, done0, gen_rst0, gen_ena0);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_done += int'(done0) + int'(busy0);
        end
        compared++;
        if (seen_done != 0) begin
            mismatched++;
            $display("FAIL abort_no_done got %0d done/busy cycles expected 0", seen_done);
        end
        expq = {};
        push_pass();
        push_idle(2);
        capture(expq.size(), -1, -1);
        for (int i = 0; i < expq.size(); i++) begin
            smp_t o;
            o = obs0[i];
            if (expq[i].grst) o.ticks = '0;
            compared++;
            if (o !== expq[i]) begin
                mismatched++;
                $display("FAIL abort_restart cycle %0d got %h expected %h", i, o, expq[i]);
            end
        end
    endtask

    task automatic test_lock();
        expq = {};
        push_pass();
        push_idle(2);
        cfg_addr  = 2'd0;
        cfg_ticks = 8'd9;
        cfg_count = 4'd2;
        capture(expq.size(), 3, -1);
        for (int i = 0; i < expq.size(); i++) begin
            smp_t o;
            o = obs0[i];
            if (expq[i].grst) o.ticks = '0;
            compared++;
            if (o !== expq[i]) begin
                mismatched++;
                $display("FAIL lock_busy cycle %0d got %h expected %h", i, o, expq[i]);
            end
        end
        wr(0, 9, 2);
        expq = {};
        push_pass();
        push_idle(2);
        capture(expq.size(), -1, -1);
        for (int i = 0; i < expq.size(); i++) begin
            smp_t o;
            o = obs0[i];
            if (expq[i].grst) o.ticks = '0;
            compared++;
            if (o !== expq[i]) begin
                mismatched++;
                $display("FAIL lock_idle_write cycle %0d got %h expected %h", i, o, expq[i]);
            end
        end
    endtask

    task automatic test_loop();
        int dones;
        wr(0, 1, 1);
        for (int a = 1; a < STEPS; a++) wr(a, int'($urandom_range(0, 15)), 0);
        expq = {};
        push_pass();
        push_idle(17);
        exp0 = expq;
        expq = {};
        repeat (3) push_pass();
        push_idle(3);
        exp1 = expq;
        loop = 1'b1;
        capture(exp1.size(), -1, 15);
        loop  = 1'b0;
        dones = 0;
        for (int i = 0; i < exp1.size(); i++) begin
            smp_t o0, o1;
            o0 = obs0[i];
            o1 = obs1[i];
            dones += int'(o1.done);
            if (exp0[i].grst) o0.ticks = '0;
            if (exp1[i].grst) o1.ticks = '0;
            compared += 2;
            if (o0 !== exp0[i]) begin
                mismatched++;
                $display("FAIL loop_ignored cycle %0d got %h expected %h", i, o0, exp0[i]);
            end
            if (o1 !== exp1[i]) begin
                mismatched++;
                $display("FAIL loop_pass cycle %0d got %h expected %h", i, o1, exp1[i]);
            end
        end
        compared++;
        if (dones != 3) begin
            mismatched++;
            $display("FAIL loop_done_count got %0d expected 3", dones);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < STEPS; a++)
                wr(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
            expq = {};
            push_pass();
            push_idle(2);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_ticks = 8'($urandom_range(0, 255));
            cfg_count = 4'($urandom_range(0, 15));
            capture(expq.size(), int'($urandom_range(0, expq.size() - 4)), -1);
            for (int i = 0; i < expq.size(); i++) begin
                smp_t o0, o1;
                o0 = obs0[i];
                o1 = obs1[i];
                if (expq[i].grst) begin
                    o0.ticks = '0;
                    o1.ticks = '0;
                end
                compared += 2;
                if (o0 !== expq[i]) begin
                    mismatched++;
                    $display("FAIL random_%0d dut0 cycle %0d got %h expected %h", it, i, o0, expq[i]);
                end
                if (o1 !== expq[i]) begin
                    mismatched++;
                    $display("FAIL random_%0d dut1 cycle %0d got %h expected %h", it, i, o1, expq[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_ticks = '0;
        cfg_count = '0;
        start     = 1'b0;
        abort     = 1'b0;
        loop      = 1'b0;
        for (int i = 0; i < STEPS; i++) begin tbl_t[i] = '0; tbl_c[i] = '0; end
        test_reset();
        test_single_step();
        test_multi_step();
        test_abort();
        test_lock();
        test_loop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
